// File: rtl/router_pkt_ctrl.sv
// Input-side packet controller of the 1x3 router: steers header/payload/parity into one FIFO and checks XOR parity.
// Optional length check is enabled by defining ROUTER_LEN_CHECK_EN.
module router_pkt_ctrl #(
    parameter int DW     = 8,
    parameter int N_DEST = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [DW-1:0]     data_in,
    input  logic [N_DEST-1:0] fifo_full,
    input  logic [N_DEST-1:0] fifo_empty,
    output logic              busy,
    output logic [N_DEST-1:0] write_enb,
    output logic              lfd_state,
    output logic [DW-1:0]     d_out,
    output logic              parity_done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_EMPTY,
        LOAD_FIRST,
        LOAD_DATA,
        CHECK_PARITY
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] hdr_q, hdr_d;
    logic [1:0]    addr_q, addr_d;
    logic [DW-1:0] calc_par_q, calc_par_d;
    logic [DW-1:0] rx_par_q, rx_par_d;
    logic          err_q, err_d;
    logic          parity_done_q, parity_done_d;
    logic          wr_req;
`ifdef ROUTER_LEN_CHECK_EN
    logic [DW-3:0] cnt_q, cnt_d;
`endif

    // Zero-extended to four entries so a 2-bit address can index them directly.
    logic [3:0] full_ext, empty_ext;
    assign full_ext  = 4'(fifo_full);
    assign empty_ext = 4'(fifo_empty);

    // NOTE: every output and next-state value gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d       = state_q;
        hdr_d         = hdr_q;
        addr_d        = addr_q;
        calc_par_d    = calc_par_q;
        rx_par_d      = rx_par_q;
        err_d         = err_q;
        parity_done_d = 1'b0;
`ifdef ROUTER_LEN_CHECK_EN
        cnt_d         = cnt_q;
`endif
        busy          = 1'b0;
        wr_req        = 1'b0;
        lfd_state     = 1'b0;
        d_out         = '0;

        unique case (state_q)
            IDLE: begin
                if (pkt_valid && int'(data_in[1:0]) < N_DEST) begin
                    hdr_d      = data_in;
                    addr_d     = data_in[1:0];
                    calc_par_d = data_in;
                    err_d      = 1'b0;
`ifdef ROUTER_LEN_CHECK_EN
                    cnt_d      = '0;
`endif
                    state_d    = empty_ext[data_in[1:0]] ? LOAD_FIRST : WAIT_EMPTY;
                end
            end
            WAIT_EMPTY: begin
                busy = 1'b1;
                if (empty_ext[addr_q]) state_d = LOAD_FIRST;
            end
            LOAD_FIRST: begin
                busy      = 1'b1;
                wr_req    = 1'b1;
                lfd_state = 1'b1;
                d_out     = hdr_q;
                state_d   = LOAD_DATA;
            end
            LOAD_DATA: begin
                busy = full_ext[addr_q];
                if (!full_ext[addr_q]) begin
                    wr_req = 1'b1;
                    d_out  = data_in;
                    if (pkt_valid) begin
                        calc_par_d = calc_par_q ^ data_in;
`ifdef ROUTER_LEN_CHECK_EN
                        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
`endif
                    end else begin
                        rx_par_d = data_in;
                        state_d  = CHECK_PARITY;
                    end
                end
            end
            CHECK_PARITY: begin
                busy          = 1'b1;
                parity_done_d = 1'b1;
`ifdef ROUTER_LEN_CHECK_EN
                err_d = (rx_par_q != calc_par_q) | (cnt_q != hdr_q[DW-1:2]);
`else
                err_d = (rx_par_q != calc_par_q);
`endif
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Nothing reaches a FIFO while reset is asserted, even from a mid-packet state.
        if (reset) begin
            busy      = 1'b0;
            wr_req    = 1'b0;
            lfd_state = 1'b0;
            d_out     = '0;
        end
        write_enb = wr_req ? N_DEST'(1 << addr_q) : '0;
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            hdr_q         <= '0;
            addr_q        <= '0;
            calc_par_q    <= '0;
            rx_par_q      <= '0;
            err_q         <= 1'b0;
            parity_done_q <= 1'b0;
`ifdef ROUTER_LEN_CHECK_EN
            cnt_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            hdr_q         <= hdr_d;
            addr_q        <= addr_d;
            calc_par_q    <= calc_par_d;
            rx_par_q      <= rx_par_d;
            err_q         <= err_d;
            parity_done_q <= parity_done_d;
`ifdef ROUTER_LEN_CHECK_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign parity_done = parity_done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// Self-checking bench for router_pkt_ctrl: directed corner cases plus random packets
// compared against a packet-level model of the FIFO write stream, parity and error flag.
module tb_router_pkt_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full, fifo_empty;
    logic       busy;
    logic [2:0] write_enb;
    logic       lfd_state;
    logic [7:0] d_out;
    logic       parity_done, err;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [2:0] we;
        logic       lfd;
        logic [7:0] d;
    } wr_t;

    wr_t        log_q[$];
    logic [7:0] pay[64];
    int         pay_n;
    logic       last_exp_err;
    logic       busy_s, lfd_s;
    logic [2:0] we_s;
    logic [7:0] d_s;

`ifdef ROUTER_LEN_CHECK_EN
    localparam bit LEN_CHK = 1'b1;
`else
    localparam bit LEN_CHK = 1'b0;
`endif

    router_pkt_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .pkt_valid   (pkt_valid),
        .data_in     (data_in),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .busy        (busy),
        .write_enb   (write_enb),
        .lfd_state   (lfd_state),
        .d_out       (d_out),
        .parity_done (parity_done),
        .err         (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Samples the combinational outputs that the coming rising edge will act on, logs any FIFO write,
    // then advances to the next falling edge where new inputs are driven.
    task automatic tick();
        wr_t w;
        #1;
        busy_s = busy;
        we_s   = write_enb;
        lfd_s  = lfd_state;
        d_s    = d_out;
        check("we_onehot", $countones(write_enb) <= 1, 1);
        check("busy_we_only_lfd", (busy && write_enb != 0) ? lfd_state : 1'b1, 1'b1);
        check("dout_zero_idle", (write_enb == 0) ? d_out : 8'h00, 8'h00);
        if (write_enb != 0) begin
            w.we  = write_enb;
            w.lfd = lfd_state;
            w.d   = d_out;
            log_q.push_back(w);
        end
        @(negedge clk);
    endtask

    // Drives one packet (header, pay[0..pay_n-1], parity) as a source obeying busy, then checks
    // the FIFO write stream, parity_done timing and err against the packet-level model.
    task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] par_flip, input int empty_wait,
                            input int full_pct, input int stall_at, input int stall_len);
        logic [1:0] dest;
        logic [7:0] par;
        logic [7:0] par_byte;
        logic       exp_err;
        int         wait_left;
        int         guard;
        int         k;
        int         n_exp;
        wr_t        e;
        dest      = hdr[1:0];
        par       = hdr;
        for (int i = 0; i < pay_n; i++) par ^= pay[i];
        par_byte  = par ^ par_flip;
        exp_err   = (par_flip != 8'h00) | (LEN_CHK && (pay_n != int'(hdr[7:2])));
        wait_left = empty_wait;
        log_q.delete();

        fifo_full        = 3'($urandom);
        fifo_empty       = 3'($urandom);
        fifo_empty[dest] = (wait_left == 0);
        pkt_valid        = 1'b1;
        data_in          = hdr;
        tick();
        check("hdr_accept_busy", busy_s, 1'b0);
        check("err_clear_on_hdr", err, 1'b0);

        for (int i = 0; i <= pay_n; i++) begin
            pkt_valid = (i < pay_n);
            data_in   = (i < pay_n) ? pay[i] : par_byte;
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    fifo_full       = 3'($urandom);
                    fifo_full[dest] = 1'b1;
                    tick();
                    check("stall_busy", busy_s, 1'b1);
                    check("stall_we", we_s, 3'b000);
                end
            end
            guard = 0;
            do begin
                fifo_full        = 3'($urandom);
                fifo_full[dest]  = ($urandom_range(99) < full_pct);
                fifo_empty       = 3'($urandom);
                fifo_empty[dest] = (wait_left == 0);
                tick();
                if (wait_left > 0) begin
                    check("wait_busy", busy_s, 1'b1);
                    check("wait_we", we_s, 3'b000);
                    wait_left--;
                end
                guard++;
            end while (busy_s && guard < 200);
            check("byte_accept", busy_s, 1'b0);
            if (busy_s) return;
        end

        pkt_valid = 1'b0;
        data_in   = 8'($urandom);
        fifo_full = 3'($urandom);
        k = 0;
        tick();
        while (!parity_done && k < 4) begin
            tick();
            k++;
        end
        check("pd_latency", k, 0);
        check("parity_done", parity_done, 1'b1);
        check("err", err, exp_err);
        tick();
        check("pd_pulse", parity_done, 1'b0);
        check("err_sticky", err, exp_err);
        last_exp_err = exp_err;

        n_exp = pay_n + 2;
        check("wr_count", log_q.size(), n_exp);
        for (int i = 0; i < n_exp && i < log_q.size(); i++) begin
            e.we  = 3'(1 << dest);
            e.lfd = (i == 0);
            e.d   = (i == 0) ? hdr : (i <= pay_n) ? pay[i-1] : par_byte;
            check("wr_entry", 32'(log_q[i]), 32'(e));
        end
    endtask

    initial begin
        reset        = 1'b1;
        pkt_valid    = 1'b1;
        data_in      = 8'h0D;
        fifo_full    = 3'b000;
        fifo_empty   = 3'b111;
        last_exp_err = 1'b0;
        pay_n        = 0;

        // Reset held for two clocks with pkt_valid active.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_busy", busy_s, 1'b0);
            check("rst_we", we_s, 3'b000);
            check("rst_lfd", lfd_s, 1'b0);
            check("rst_dout", d_s, 8'h00);
        end
        check("rst_err", err, 1'b0);
        check("rst_pd", parity_done, 1'b0);
        reset     = 1'b0;
        pkt_valid = 1'b0;
        tick();
        check("post_rst_idle", busy_s, 1'b0);

        // Good packet to FIFO1.
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay_n = 3;
        send_pkt(8'h0D, 8'h00, 0, 0, -1, 0);
        // Same packet with parity byte 0x00.
        send_pkt(8'h0D, 8'h0D, 0, 0, -1, 0);
        // FIFO2 not empty for three cycles at header time.
        pay[0] = 8'hA5; pay_n = 1;
        send_pkt(8'h06, 8'h00, 3, 0, -1, 0);
        // FIFO0 full for four cycles mid-payload.
        for (int i = 0; i < 6; i++) pay[i] = 8'($urandom);
        pay_n = 6;
        send_pkt(8'h18, 8'h00, 0, 0, 3, 4);

        // Header addressed to dest 3 is dropped without touching err.
        pkt_valid  = 1'b1;
        data_in    = 8'h0B;
        fifo_empty = 3'b111;
        tick();
        check("dest3_busy", busy_s, 1'b0);
        check("dest3_we", we_s, 3'b000);
        tick();
        check("dest3_stay_idle", busy_s, 1'b0);
        check("dest3_we2", we_s, 3'b000);
        check("dest3_err", err, last_exp_err);
        pkt_valid = 1'b0;

        // Header length 2 but three payload bytes; only flagged with the length check built in.
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay_n = 3;
        send_pkt(8'h08, 8'h00, 0, 0, -1, 0);
        // Zero-length packet: parity directly after header.
        pay_n = 0;
        send_pkt(8'h01, 8'h00, 0, 20, -1, 0);

        // Reset mid-payload returns to IDLE and suppresses the write on the reset edge.
        fifo_full  = 3'b000;
        fifo_empty = 3'b111;
        pkt_valid  = 1'b1;
        data_in    = 8'h0D;
        tick();
        data_in = 8'h11;
        tick();
        tick();
        data_in = 8'h22;
        reset   = 1'b1;
        tick();
        check("midrst_we", we_s, 3'b000);
        reset     = 1'b0;
        pkt_valid = 1'b0;
        fifo_full = 3'b111;
        tick();
        check("midrst_idle", busy_s, 1'b0);
        check("midrst_err", err, 1'b0);
        check("midrst_pd", parity_done, 1'b0);

        // Random packets with random back-pressure, empty waits and corrupted parity.
        for (int p = 0; p < 30; p++) begin
            logic [1:0] dest;
            logic [7:0] flip;
            dest  = 2'($urandom_range(2));
            pay_n = $urandom_range(12);
            for (int i = 0; i < pay_n; i++) pay[i] = 8'($urandom);
            flip  = ($urandom_range(3) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            send_pkt({6'(pay_n), dest}, flip, $urandom_range(3), 30, -1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
